useq_ctrl: RTL and testbench
============================

# useq_ctrl

Parametrised microprogram sequencer for the control unit: each clock it selects the next microaddress from the current microinstruction's sequencing fields, the condition flags and a writable opcode dispatch table, and registers it into the microprogram counter. It adds multi-flag conditional branches, wait states, a microsubroutine call/return stack, stall and a runtime-loadable dispatch map. The control-store ROM sits outside the block: `upc` addresses the ROM, and the ROM's sequencing fields feed back combinationally in the same cycle.

## Interface
- `AW`, 5: microaddress width.
- `OPW`, 8: opcode width; the dispatch table has 2^OPW entries of AW bits.
- `NCOND`, 4: number of condition flags; bit 0 is Z.
- `DEPTH`, 4: call-stack depth (≥1).
- `RESET_ADDR`, 0: microaddress loaded on reset and on a stack underflow.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: holds all state when high.
- `op` in OPW: opcode from IR.
- `cond` in NCOND: condition flags.
- `seq_op` in 3: sequencing opcode of the current microinstruction.
- `seq_sel` in clog2(NCOND) (min 1): selects the condition flag.
- `seq_naddr` in AW: target microaddress.
- `map_we` in 1: dispatch-table write enable.
- `map_waddr` in OPW: table index to write.
- `map_wdata` in AW: table entry value.
- `upc` out AW: registered microprogram counter; drives the ROM.
- `sp` out clog2(DEPTH+1): stack occupancy.
- `err` out 1: sticky stack overflow/underflow flag.

## Operation
- Let `inc` = (upc+1) mod 2^AW; wrap from 2^AW−1 to 0 is legal and silent. Let `c` = cond[seq_sel]; a `seq_sel` ≥ NCOND reads as 0.
- `seq_op` encodings; "next" is the value loaded into `upc` at the clock edge:
  - 0 NEXT: next = `inc`.
  - 1 JUMP: next = `seq_naddr`.
  - 2 BT: next = `seq_naddr` if c=1, else `inc`.
  - 3 BF: next = `seq_naddr` if c=0, else `inc`.
  - 4 MAP: next = map[op]. This is the value before any same-cycle write.
  - 5 CALL: push `inc`, then next = `seq_naddr`.
    - If `sp`=DEPTH: no push, `err` is set, and the jump is still taken.
  - 6 RET: pop; next = the popped address.
    - If `sp`=0: next = RESET_ADDR and `err` is set.
  - 7 WAIT: next = `inc` if c=1, else `upc` (hold).
- Stack:
  - LIFO of AW-bit entries.
  - `sp` counts valid entries, 0..DEPTH.
  - Only CALL and RET change it.
- Map write:
  - When `map_we`=1, map[map_waddr] ← `map_wdata` at the edge.
  - Allowed during stall.
  - If it writes the same index a MAP dispatch reads that cycle, the dispatch gets the old entry; the new entry is visible from the next cycle.
- Stall:
  - With `stall`=1, `upc`, the stack, `sp` and `err` hold, and `seq_op` is ignored.
  - Map writes still occur.
- Reset:
  - `reset`=1 at an edge sets `upc`=RESET_ADDR, `sp`=0, `err`=0, and every map entry to 0.
  - Reset overrides `stall`, `map_we` and any `seq_op`, including mid-call.
  - Stack contents become don't-care.
- `err` clears only on reset.

## Timing
- One microinstruction per cycle. The fields presented while `upc`=A belong to address A; the chosen successor appears on `upc` after the next rising edge.
- The next-address logic is combinational from `upc`-driven ROM fields, `cond` and `op` to the `upc` D input. There are no internal pipeline stages.
- `sp` and `err` update on the same edge as `upc`.
- Reset values: `upc`=RESET_ADDR, `sp`=0, `err`=0. These are visible in the cycle after reset is sampled.
- The first edge after `reset` deasserts executes the microinstruction at RESET_ADDR.

## Test plan
- Reset + NEXT/wrap:
  - Hold reset 2 cycles → `upc`=0, `sp`=0, `err`=0.
  - NEXT ×31 → `upc`=31; one more NEXT → `upc`=0.
- Dispatch and write collision:
  - Write map[0x3C]=0x12.
  - MAP with op=0x3C → `upc`=0x12.
  - Same cycle: MAP op=0x05 while writing map[0x05]=0x1A → `upc`=0 (old entry). Repeat MAP op=0x05 → `upc`=0x1A.
- Branches/wait:
  - `upc`=4, BT sel=0, cond=0001, naddr=0x10 → 0x10.
  - BF under the same conditions → 5.
  - WAIT sel=2 with cond[2]=0 for 3 cycles → `upc` stays 4; cond[2]=1 → 5.
- Call nesting/overflow:
  - CALL from `upc` 1, 2, 3, 4 (naddr 8) → `sp`=4.
  - Fifth CALL from `upc`=9 → `upc`=8, `sp`=4, `err`=1.
  - Four RETs → `upc` 5, 4, 3, 2, `sp`=0.
- Underflow/stall:
  - RET with `sp`=0 at `upc`=7 → `upc`=0, `err`=1.
  - With `stall`=1 during a CALL, `upc`, `sp` and `err` are unchanged; a map write during the stall still lands.
- Reset mid-call:
  - With `sp`=2, assert reset during a CALL with `stall`=1 → `upc`=0, `sp`=0, `err`=0, and MAP with op=0x3C yields 0.

Source files
------------

// File: rtl/useq_ctrl.sv
// Microprogram sequencer: picks the next microaddress from the current sequencing
// fields, condition flags, a writable opcode dispatch map and a call/return stack.
module useq_ctrl #(
    parameter int AW         = 5,
    parameter int OPW        = 8,
    parameter int NCOND      = 4,
    parameter int DEPTH      = 4,
    parameter int RESET_ADDR = 0,
    parameter int SELW       = (NCOND > 1) ? $clog2(NCOND) : 1,
    parameter int SPW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [OPW-1:0]   op,
    input  logic [NCOND-1:0] cond,
    input  logic [2:0]       seq_op,
    input  logic [SELW-1:0]  seq_sel,
    input  logic [AW-1:0]    seq_naddr,
    input  logic             map_we,
    input  logic [OPW-1:0]   map_waddr,
    input  logic [AW-1:0]    map_wdata,
    output logic [AW-1:0]    upc,
    output logic [SPW-1:0]   sp,
    output logic             err
);

    localparam int          NMAP  = 2 ** OPW;
    localparam logic [AW-1:0]  RST_A  = AW'(RESET_ADDR);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    typedef enum logic [2:0] {
        SEQ_NEXT = 3'd0,
        SEQ_JUMP = 3'd1,
        SEQ_BT   = 3'd2,
        SEQ_BF   = 3'd3,
        SEQ_MAP  = 3'd4,
        SEQ_CALL = 3'd5,
        SEQ_RET  = 3'd6,
        SEQ_WAIT = 3'd7
    } seq_op_e;

    logic [AW-1:0]  upc_r;
    logic [SPW-1:0] sp_r;
    logic           err_r;
    logic [AW-1:0]  map_r   [NMAP];
    logic [AW-1:0]  stack_r [DEPTH];

    logic [AW-1:0]  inc_s;
    logic [AW-1:0]  next_s;
    logic [AW-1:0]  top_s;
    logic           c_s;
    logic           push_s;
    logic           pop_s;
    logic           err_set_s;

    assign inc_s = upc_r + AW'(1);

    // Condition select; an out-of-range selector reads as 0.
    always_comb begin
        c_s = 1'b0;
        for (int i = 0; i < NCOND; i++) begin
            c_s = c_s | (cond[i] & (seq_sel == SELW'(i)));
        end
    end

    // Top-of-stack read, entry sp-1.
    always_comb begin
        top_s = {AW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            top_s = (sp_r == SPW'(i + 1)) ? stack_r[i] : top_s;
        end
    end

    // Next-address selection and stack control for the current microinstruction.
    always_comb begin
        next_s    = inc_s;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        err_set_s = 1'b0;
        case (seq_op_e'(seq_op))
            SEQ_NEXT: next_s = inc_s;
            SEQ_JUMP: next_s = seq_naddr;
            SEQ_BT:   next_s = c_s ? seq_naddr : inc_s;
            SEQ_BF:   next_s = c_s ? inc_s : seq_naddr;
            SEQ_MAP:  next_s = map_r[op];
            SEQ_CALL: begin
                next_s = seq_naddr;
                if (sp_r == SP_FULL) begin
                    err_set_s = 1'b1;
                end else begin
                    push_s = 1'b1;
                end
            end
            SEQ_RET: begin
                if (sp_r == {SPW{1'b0}}) begin
                    next_s    = RST_A;
                    err_set_s = 1'b1;
                end else begin
                    next_s = top_s;
                    pop_s  = 1'b1;
                end
            end
            SEQ_WAIT: next_s = c_s ? inc_s : upc_r;
            default:  next_s = inc_s;
        endcase
    end

    // Microprogram counter, occupancy, sticky error and dispatch map.
    always_ff @(posedge clk) begin
        if (reset) begin
            upc_r <= RST_A;
            sp_r  <= {SPW{1'b0}};
            err_r <= 1'b0;
            for (int i = 0; i < NMAP; i++) begin
                map_r[i] <= {AW{1'b0}};
            end
        end else begin
            if (map_we) begin
                map_r[map_waddr] <= map_wdata;
            end
            if (!stall) begin
                upc_r <= next_s;
                err_r <= err_r | err_set_s;
                if (push_s) begin
                    sp_r <= sp_r + SPW'(1);
                end else if (pop_s) begin
                    sp_r <= sp_r - SPW'(1);
                end
            end
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset && !stall && push_s && (sp_r == SPW'(i))) begin
                stack_r[i] <= inc_s;
            end
        end
    end

    assign upc = upc_r;
    assign sp  = sp_r;
    assign err = err_r;

endmodule

// File: tb/tb_useq_ctrl.sv
// Directed bench for useq_ctrl: expected state is queued when a step is driven
// and compared after the clock edge that executes it.
module tb_useq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic [7:0] op;
    logic [3:0] cond;
    logic [2:0] seq_op;
    logic [1:0] seq_sel;
    logic [4:0] seq_naddr;
    logic       map_we;
    logic [7:0] map_waddr;
    logic [4:0] map_wdata;
    logic [4:0] upc;
    logic [2:0] sp;
    logic       err;

    typedef struct packed {
        logic [4:0] upc;
        logic [2:0] sp;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, BT = 3'd2, BF = 3'd3,
                           MAP = 3'd4, CALL = 3'd5, RET = 3'd6, WAIT = 3'd7;

    useq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .op        (op),
        .cond      (cond),
        .seq_op    (seq_op),
        .seq_sel   (seq_sel),
        .seq_naddr (seq_naddr),
        .map_we    (map_we),
        .map_waddr (map_waddr),
        .map_wdata (map_wdata),
        .upc       (upc),
        .sp        (sp),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [2:0] o, input logic [1:0] s,
                         input logic [4:0] a, input logic [3:0] c, input logic [7:0] opc);
        seq_op    = o;
        seq_sel   = s;
        seq_naddr = a;
        cond      = c;
        op        = opc;
    endtask

    task automatic tick(input string tag, input logic [4:0] e_upc,
                        input logic [2:0] e_sp, input logic e_err);
        exp_t e;
        exp_q.push_back('{upc: e_upc, sp: e_sp, err: e_err});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        vectors++;
        assert (upc === e.upc) else begin
            miscompares++;
            $error("FAIL %s upc observed=%0h expected=%0h", tag, upc, e.upc);
        end
        vectors++;
        assert (sp === e.sp) else begin
            miscompares++;
            $error("FAIL %s sp observed=%0d expected=%0d", tag, sp, e.sp);
        end
        vectors++;
        assert (err === e.err) else begin
            miscompares++;
            $error("FAIL %s err observed=%0b expected=%0b", tag, err, e.err);
        end
        stall     = 1'b0;
        map_we    = 1'b0;
        map_waddr = 8'h00;
        map_wdata = 5'h00;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; map_we = 1'b0; map_waddr = 8'h00; map_wdata = 5'h00;
        issue(NEXT, 2'd0, 5'h00, 4'h0, 8'h00);
        tick("reset1", 5'h00, 3'd0, 1'b0);
        tick("reset2", 5'h00, 3'd0, 1'b0);
        reset = 1'b0;

        // NEXT sweep and wrap
        for (int i = 1; i <= 31; i++) begin
            tick("next", 5'(i), 3'd0, 1'b0);
        end
        tick("wrap", 5'h00, 3'd0, 1'b0);

        // Dispatch map and same-cycle write collision
        map_we = 1'b1; map_waddr = 8'h3C; map_wdata = 5'h12;
        tick("mapwr", 5'h01, 3'd0, 1'b0);
        issue(MAP, 2'd0, 5'h00, 4'h0, 8'h3C);
        tick("map3c", 5'h12, 3'd0, 1'b0);
        issue(MAP, 2'd0, 5'h00, 4'h0, 8'h05);
        map_we = 1'b1; map_waddr = 8'h05; map_wdata = 5'h1A;
        tick("mapcoll", 5'h00, 3'd0, 1'b0);
        tick("mapnew", 5'h1A, 3'd0, 1'b0);

        // Branches and wait
        issue(JUMP, 2'd0, 5'h04, 4'h0, 8'h00); tick("jmp4a", 5'h04, 3'd0, 1'b0);
        issue(BT, 2'd0, 5'h10, 4'b0001, 8'h00); tick("bt", 5'h10, 3'd0, 1'b0);
        issue(JUMP, 2'd0, 5'h04, 4'h0, 8'h00); tick("jmp4b", 5'h04, 3'd0, 1'b0);
        issue(BF, 2'd0, 5'h10, 4'b0001, 8'h00); tick("bf", 5'h05, 3'd0, 1'b0);
        issue(JUMP, 2'd0, 5'h04, 4'h0, 8'h00); tick("jmp4c", 5'h04, 3'd0, 1'b0);
        issue(WAIT, 2'd2, 5'h00, 4'b1011, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick("waithold", 5'h04, 3'd0, 1'b0);
        end
        issue(WAIT, 2'd2, 5'h00, 4'b0100, 8'h00); tick("waitgo", 5'h05, 3'd0, 1'b0);

        // Call nesting, overflow and returns
        for (int i = 1; i <= 4; i++) begin
            issue(JUMP, 2'd0, 5'(i), 4'h0, 8'h00); tick("jmpc", 5'(i), 3'(i - 1), 1'b0);
            issue(CALL, 2'd0, 5'h08, 4'h0, 8'h00); tick("call", 5'h08, 3'(i), 1'b0);
        end
        issue(JUMP, 2'd0, 5'h09, 4'h0, 8'h00); tick("jmp9", 5'h09, 3'd4, 1'b0);
        issue(CALL, 2'd0, 5'h08, 4'h0, 8'h00); tick("ovf", 5'h08, 3'd4, 1'b1);
        issue(RET, 2'd0, 5'h00, 4'h0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick("ret", 5'(5 - i), 3'(3 - i), 1'b1);
        end

        // Underflow, then stall with a map write
        issue(JUMP, 2'd0, 5'h07, 4'h0, 8'h00); tick("jmp7", 5'h07, 3'd0, 1'b1);
        issue(RET, 2'd0, 5'h00, 4'h0, 8'h00); tick("unf", 5'h00, 3'd0, 1'b1);
        issue(CALL, 2'd0, 5'h08, 4'h0, 8'h00);
        stall = 1'b1; map_we = 1'b1; map_waddr = 8'h22; map_wdata = 5'h0B;
        tick("stall", 5'h00, 3'd0, 1'b1);
        issue(MAP, 2'd0, 5'h00, 4'h0, 8'h22); tick("stallmap", 5'h0B, 3'd0, 1'b1);

        // Reset during a stalled call with two frames live
        issue(CALL, 2'd0, 5'h08, 4'h0, 8'h00);
        tick("call1", 5'h08, 3'd1, 1'b1);
        tick("call2", 5'h08, 3'd2, 1'b1);
        reset = 1'b1; stall = 1'b1; map_we = 1'b1; map_waddr = 8'h3C; map_wdata = 5'h1F;
        tick("rstmid", 5'h00, 3'd0, 1'b0);
        reset = 1'b0;
        issue(MAP, 2'd0, 5'h00, 4'h0, 8'h3C); tick("rstmap", 5'h00, 3'd0, 1'b0);
        issue(MAP, 2'd0, 5'h00, 4'h0, 8'h05); tick("rstmap5", 5'h00, 3'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
